// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen: synchronises and debounces a raw button/strobe. It emits one
// registered single-cycle pulse per accepted press and counts the emitted pulses.
//
// Ports:
//   clk        system clock; all logic runs on posedge
//   rst        synchronous active-high reset
//   btn_in     raw asynchronous button/strobe; may bounce
//   en         pulse enable; a press accepted while low is dropped, not deferred
//   clr_cnt    synchronous clear of pulse_cnt and cnt_wrap; wins over an increment
//   pulse      registered one-cycle pulse on each accepted press (drives toggle FSM din)
//   level      registered debounced level
//   pulse_cnt  emitted-pulse count, wraps modulo 2^CNT_W
//   cnt_wrap   sticky flag, set when pulse_cnt wraps from all-ones to zero
module debounce_pulse_gen #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             pulse,
  output logic             level,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             cnt_wrap
);

  localparam int unsigned STB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [STB_W-1:0] stb_cnt;
  logic [STB_W-1:0] stb_cnt_nx;
  logic             pulse_nx;
  logic             level_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s_in;
  logic             stb_done;

  // Input synchroniser; the FSM only ever looks at the last stage.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign s_in = sync_q[SYNC_STAGES-1];

  // True when the current sample completes the required run of stable samples.
  assign stb_done = ((32'(stb_cnt) + 32'd1) == 32'(DEBOUNCE_CYCLES));

  // State, stable counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE_LO;
      stb_cnt <= '0;
      pulse   <= 1'b0;
      level   <= 1'b0;
    end else begin
      state   <= state_nx;
      stb_cnt <= stb_cnt_nx;
      pulse   <= pulse_nx;
      level   <= level_nx;
    end
  end

  // Next-state logic: a level change is accepted after DEBOUNCE_CYCLES matching samples.
  always_comb begin
    state_nx   = state;
    stb_cnt_nx = stb_cnt;
    pulse_nx   = 1'b0;
    level_nx   = level;
    case (state)
      IDLE_LO: begin
        if (s_in) begin
          state_nx   = WAIT_HI;
          stb_cnt_nx = STB_W'(1);
        end
      end
      WAIT_HI: begin
        if (!s_in) begin
          state_nx   = IDLE_LO;
          stb_cnt_nx = '0;
        end else if (stb_done) begin
          state_nx   = STABLE_HI;
          stb_cnt_nx = '0;
          level_nx   = 1'b1;
          pulse_nx   = en;
        end else begin
          stb_cnt_nx = stb_cnt + STB_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s_in) begin
          state_nx   = WAIT_LO;
          stb_cnt_nx = STB_W'(1);
        end
      end
      WAIT_LO: begin
        if (s_in) begin
          state_nx   = STABLE_HI;
          stb_cnt_nx = '0;
        end else if (stb_done) begin
          state_nx   = IDLE_LO;
          stb_cnt_nx = '0;
          level_nx   = 1'b0;
        end else begin
          stb_cnt_nx = stb_cnt + STB_W'(1);
        end
      end
      default: begin
        state_nx   = IDLE_LO;
        stb_cnt_nx = '0;
        level_nx   = 1'b0;
      end
    endcase
  end

  // Pulse counter. A clear in the same cycle as a pulse wins, so that pulse is not counted.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      pulse_cnt <= '0;
      cnt_wrap  <= 1'b0;
    end else if (pulse_nx) begin
      pulse_cnt <= pulse_cnt + CNT_W'(1);
      if (&pulse_cnt) cnt_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Scoreboarded bench for debounce_pulse_gen, driven by directed and random stimulus.
module tb_debounce_pulse_gen;

  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_in;
  logic          en;
  logic          clr_cnt;
  logic          pulse;
  logic          level;
  logic [CW-1:0] pulse_cnt;
  logic          cnt_wrap;

  always #5 clk = ~clk;

  debounce_pulse_gen #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .en(en),
    .clr_cnt(clr_cnt),
    .pulse(pulse),
    .level(level),
    .pulse_cnt(pulse_cnt),
    .cnt_wrap(cnt_wrap)
  );

  typedef struct {
    int          cyc;
    logic [CW-1:0] cnt;
    logic        wrap;
  } pexp_t;

  typedef struct {
    logic        lvl;
    logic [CW-1:0] cnt;
    logic        wrap;
  } sexp_t;

  pexp_t pq[$];
  sexp_t sq[$];
  pexp_t pe;
  sexp_t se;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  // Reference model: btn delay line, recent FSM samples, and the architectural outputs.
  logic          bq[$];
  logic          samp[$];
  logic          m_level;
  logic [CW-1:0] m_cnt;
  logic          m_wrap;

  logic bp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic model_reset();
    bq.delete();
    for (int i = 0; i < int'(SS); i++) bq.push_back(1'b0);
    samp.delete();
    m_level = 1'b0;
    m_cnt   = '0;
    m_wrap  = 1'b0;
  endtask

  // Apply one cycle of inputs, then advance the model across the same clock edge.
  task automatic step(input logic b, input logic e, input logic c, input logic r);
    logic s;
    logic flip;
    logic p;
    btn_in  = b;
    en      = e;
    clr_cnt = c;
    rst     = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      s = bq.pop_front();
      bq.push_back(b);
      samp.push_back(s);
      if (samp.size() > int'(DC)) void'(samp.pop_front());
      // The level flips once the last DC samples all disagree with it.
      flip = (samp.size() == int'(DC));
      foreach (samp[i]) if (samp[i] == m_level) flip = 1'b0;
      p = 1'b0;
      if (flip) begin
        m_level = !m_level;
        p       = m_level && e;
        samp.delete();
      end
      if (c) begin
        m_cnt  = '0;
        m_wrap = 1'b0;
      end else if (p) begin
        if (m_cnt == '1) m_wrap = 1'b1;
        m_cnt = m_cnt + 1'b1;
      end
      if (p) pq.push_back('{cyc, m_cnt, m_wrap});
    end
    sq.push_back('{m_level, m_cnt, m_wrap});
    #1;
  endtask

  // Monitor: check status every cycle; when pulse is seen, match it against the pulse queue.
  always @(negedge clk) begin
    if (sq.size() > 0) begin
      se = sq.pop_front();
      total++;
      if (level !== se.lvl || pulse_cnt !== se.cnt || cnt_wrap !== se.wrap) begin
        bad++;
        $display("FAIL status cyc=%0d got level=%b cnt=%0d wrap=%b want level=%b cnt=%0d wrap=%b",
                 cyc, level, pulse_cnt, cnt_wrap, se.lvl, se.cnt, se.wrap);
      end
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      pe = pq.pop_front();
      total++;
      bad++;
      $display("FAIL missed_pulse cyc=%0d got pulse=0 want pulse=1 at cyc=%0d", cyc, pe.cyc);
    end
    if (cyc > 0 && pulse !== 1'b0) begin
      total++;
      if (pq.size() == 0 || pq[0].cyc != cyc) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got pulse=%b want pulse=0", cyc, pulse);
      end else begin
        pe = pq.pop_front();
        if (pulse_cnt !== pe.cnt || cnt_wrap !== pe.wrap) begin
          bad++;
          $display("FAIL pulse_count cyc=%0d got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                   cyc, pulse_cnt, cnt_wrap, pe.cnt, pe.wrap);
        end
      end
    end
  end

  initial begin
    logic tgt;
    logic b;
    model_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Clean press and release.
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Bounce rejected, then a real hold.
    foreach (bp[i]) step(bp[i], 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Release glitch, then a real release.
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2)  step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5)  step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Press with en low; raising en mid-hold must not pulse.
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Counter wrap, then clear coincident with the next pulse.
    for (int k = 0; k < 256; k++) begin
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, i == 5, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-debounce with the button still held.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, i == 5);
    repeat (15) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Random bouncy traffic with random enable, clear and reset.
    tgt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) tgt = !tgt;
      b = ($urandom_range(4) == 0) ? !tgt : tgt;
      step(b, $urandom_range(3) != 0, $urandom_range(63) == 0, $urandom_range(499) == 0);
    end
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("FAIL pending_pulses got outstanding=%0d want 0", pq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
